// File: rtl/toyrisc_pkg.sv
// Shared ToyRISC front-end definitions (fetch today, decode next).
package toyrisc_pkg;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  // One fetched word together with the address it was read from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO for fetched words. Reset beats flush; the head
// reads as all-zero whenever the FIFO is empty so decode never sees stale data.
module fetch_fifo
  import toyrisc_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic          head_valid,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy bookkeeping; flush drops everything, including a
  // same-cycle push.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= ptr_next(r_wr);
      if (pop)  r_rd <= ptr_next(r_rd);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, kept out of reset so it maps onto plain registers/RAM.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) r_mem[r_wr] <= push_data;
  end

  assign head_valid = (r_count != '0);
  assign head       = head_valid ? r_mem[r_rd] : '0;
  assign count      = r_count;

  // The fetch issue rule reserves space for every in-flight word.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    (push && !pop && !flush) |-> (r_count != CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clock) disable iff (reset)
    (pop && !flush) |-> (r_count != '0));
endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, hides the program memory's
// one-cycle read latency behind a small FIFO, and flushes on redirect.
module fetch_controller #(
  parameter int                ADDR_W   = toyrisc_pkg::ADDR_W,
  parameter int                INSTR_W  = toyrisc_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = toyrisc_pkg::RESET_PC,
  parameter int                DEPTH    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [OW-1:0]     w_occ;
  logic [CW-1:0]     w_count;
  logic              w_head_valid;
  entry_t            w_head;
  entry_t            w_push_data;

  // Issue only if the FIFO can still hold every word already committed to it
  // (buffered + in flight), after accounting for this cycle's pop.
  always_comb begin
    w_pop   = w_head_valid & out_ready;
    w_push  = r_inflight & ~redirect_valid & ~reset;
    w_occ   = OW'(w_count) + OW'(r_inflight) - OW'(w_pop);
    w_issue = run & ~redirect_valid & ~reset & (w_occ < OW'(DEPTH));
    w_push_data.instr = instruction;
    w_push_data.pc    = r_inflight_pc;
  end

  // PC and in-flight tracking; a redirect drops the outstanding read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + ADDR_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (w_push),
    .push_data  (w_push_data),
    .pop        (w_pop),
    .flush      (redirect_valid),
    .head       (w_head),
    .head_valid (w_head_valid),
    .count      (w_count)
  );

  assign instr_addr = r_pc;
  assign out_valid  = w_head_valid;
  assign out_instr  = w_head.instr;
  assign out_pc     = w_head.pc;
endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: cycle table from reset, scoreboarded corner
// sequences, and a second instance started near the top of the address space.
module tb_fetch_controller;
  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, run, redirect_valid, out_ready, out_valid;
  logic [15:0] redirect_target, instr_addr, out_pc;
  logic [31:0] instruction, out_instr;

  logic        reset2, run2, rv2, rdy2, out_valid2;
  logic [15:0] tgt2, instr_addr2, out_pc2;
  logic [31:0] instruction2, out_instr2;

  fetch_controller dut (
    .clock(clock), .reset(reset), .run(run), .instr_addr(instr_addr),
    .instruction(instruction), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready));

  fetch_controller #(.RESET_PC(16'hFFFE)) dut2 (
    .clock(clock), .reset(reset2), .run(run2), .instr_addr(instr_addr2),
    .instruction(instruction2), .redirect_valid(rv2),
    .redirect_target(tgt2), .out_valid(out_valid2),
    .out_instr(out_instr2), .out_pc(out_pc2), .out_ready(rdy2));

  // Program memory contents are a fixed function of the address.
  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'h5A3C, a};
  endfunction

  // Registered-read program memories, zero while in reset.
  always @(posedge clock) instruction  <= reset  ? 32'h0 : memf(instr_addr);
  always @(posedge clock) instruction2 <= reset2 ? 32'h0 : memf(instr_addr2);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected pcs queued by the sequences, consumed on each pop.
  logic [15:0] sb_q[$];
  bit          sb_en = 1'b0;

  always @(negedge clock) begin
    if (sb_en && out_valid && out_ready) begin
      logic [15:0] e;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h expected no output", out_pc);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", 32'(out_pc), 32'(e));
        check("sb_instr", out_instr, memf(e));
      end
    end
  end

  typedef struct {
    logic        run;
    logic        rdy;
    logic        rv;
    logic [15:0] tgt;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] eaddr;
  } vec_t;
  vec_t tbl[12];

  task automatic setv(input int i, input logic r, input logic y, input logic v,
                      input logic [15:0] t, input logic e, input logic [15:0] p,
                      input logic [15:0] a);
    tbl[i] = '{r, y, v, t, e, p, a};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 16'h0;
    sb_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [15:0] exp2 [4];
  int          got;

  initial begin
    reset2 = 1'b1; run2 = 1'b1; rv2 = 1'b0; rdy2 = 1'b1; tgt2 = 16'h0;
    reset = 1'b1; run = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = 16'h0;

    // Reset state.
    tick();
    @(negedge clock);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", 32'(out_pc), 32'h0);
    check("rst_addr", 32'(instr_addr), 32'h0);

    // Cycle table from reset release: startup latency, back-pressure, redirect.
    setv(0,  1, 1, 0, 16'h0,  0, 16'h0,  16'h0);
    setv(1,  1, 1, 0, 16'h0,  0, 16'h0,  16'h1);
    setv(2,  1, 1, 0, 16'h0,  1, 16'h0,  16'h2);
    setv(3,  1, 1, 0, 16'h0,  1, 16'h1,  16'h3);
    setv(4,  1, 0, 0, 16'h0,  1, 16'h2,  16'h4);
    setv(5,  1, 0, 0, 16'h0,  1, 16'h2,  16'h4);
    setv(6,  1, 1, 0, 16'h0,  1, 16'h2,  16'h4);
    setv(7,  1, 1, 0, 16'h0,  1, 16'h3,  16'h5);
    setv(8,  1, 1, 1, 16'h20, 1, 16'h4,  16'h6);
    setv(9,  1, 1, 0, 16'h0,  0, 16'h0,  16'h20);
    setv(10, 1, 1, 0, 16'h0,  0, 16'h0,  16'h21);
    setv(11, 1, 1, 0, 16'h0,  1, 16'h20, 16'h22);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run = tbl[i].run; out_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
      @(negedge clock);
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d_pc", i), 32'(out_pc), tbl[i].ev ? 32'(tbl[i].epc) : 32'h0);
      check($sformatf("tbl%0d_instr", i), out_instr, tbl[i].ev ? memf(tbl[i].epc) : 32'h0);
      check($sformatf("tbl%0d_addr", i), 32'(instr_addr), 32'(tbl[i].eaddr));
      tick();
    end
    redirect_valid = 1'b0;

    sb_en = 1'b1;

    // Stall until full, then redirect: head consumed, buffered pc 2 flushed.
    do_reset();
    sb_q = '{16'h0, 16'h1, 16'h20, 16'h21, 16'h22};
    run = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("stall_addr", 32'(instr_addr), 32'h3);
      check("stall_head", 32'(out_pc), 32'h1);
      tick();
    end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h20;
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("redir_addr", 32'(instr_addr), 32'h20);
    check("redir_gap1", 32'(out_valid), 32'h0);
    tick();
    @(negedge clock);
    check("redir_gap2", 32'(out_valid), 32'h0);
    tick();
    @(negedge clock);
    check("redir_first", 32'(out_valid), 32'h1);
    tick();
    run = 1'b0;
    repeat (4) tick();
    check("redir_drained", 32'(sb_q.size()), 32'h0);

    // run=0 with one fetch in flight: it is delivered, then everything holds.
    do_reset();
    sb_q = '{16'h0, 16'h1, 16'h2};
    run = 1'b1; out_ready = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("run0_addr", 32'(instr_addr), 32'h1);
      if (k >= 2) check("run0_idle", 32'(out_valid), 32'h0);
      tick();
    end
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    repeat (4) tick();
    check("run0_drained", 32'(sb_q.size()), 32'h0);

    // Back-to-back redirects: the last target wins.
    do_reset();
    sb_q = '{16'h0, 16'h1, 16'h2, 16'h80, 16'h81};
    run = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_target = 16'h40;
    tick();
    redirect_target = 16'h80;
    @(negedge clock);
    check("b2b_addr1", 32'(instr_addr), 32'h40);
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("b2b_addr2", 32'(instr_addr), 32'h80);
    check("b2b_gap1", 32'(out_valid), 32'h0);
    tick();
    @(negedge clock);
    check("b2b_gap2", 32'(out_valid), 32'h0);
    tick();
    run = 1'b0;
    @(negedge clock);
    check("b2b_first", 32'(out_valid), 32'h1);
    repeat (3) tick();
    check("b2b_drained", 32'(sb_q.size()), 32'h0);

    // Reset mid-stream with a full FIFO.
    do_reset();
    run = 1'b1; out_ready = 1'b0;
    repeat (6) tick();
    @(negedge clock);
    check("full_valid", 32'(out_valid), 32'h1);
    check("full_head", 32'(out_pc), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("mrst_valid", 32'(out_valid), 32'h0);
    check("mrst_instr", out_instr, 32'h0);
    check("mrst_addr", 32'(instr_addr), 32'h0);
    sb_q = '{16'h0, 16'h1, 16'h2};
    out_ready = 1'b1;
    repeat (3) tick();
    run = 1'b0;
    repeat (4) tick();
    check("mrst_drained", 32'(sb_q.size()), 32'h0);

    // Random back-pressure: order and continuity checked by the scoreboard.
    do_reset();
    for (int i = 0; i < 60; i++) sb_q.push_back(16'(i));
    run = 1'b1;
    for (int k = 0; k < 60; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    run = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    check("rand_progress", 32'((60 - sb_q.size()) >= 20), 32'h1);
    sb_en = 1'b0;

    // PC wrap from a reset PC near the top of the address space.
    exp2 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    got = 0;
    tick();
    tick();
    reset2 = 1'b0;
    for (int k = 0; k < 12 && got < 4; k++) begin
      @(negedge clock);
      if (k < 2) check("wrap_latency", 32'(out_valid2), 32'h0);
      if (out_valid2) begin
        check("wrap_pc", 32'(out_pc2), 32'(exp2[got]));
        check("wrap_instr", out_instr2, memf(exp2[got]));
        got++;
      end
      tick();
    end
    check("wrap_count", 32'(got), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
